// File: rtl/ahb_lite_master.sv
// -----------------------------------------------------------------------------
// ahb_lite_master
//
// Single-transfer AHB-Lite master. Turns one command at a time from a simple
// valid/ready command interface into an AHB NONSEQ SINGLE transfer. It returns
// a one-cycle response pulse with error status, read data and the number of
// data-phase wait states. Misaligned commands are rejected locally and never
// reach the bus.
//
// Ports
//   HCLK_i, HRESETn_i         bus clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o   command handshake (ready is registered)
//   cmd_write_i               1 = write, 0 = read
//   cmd_addr_i                byte address
//   cmd_size_i                HSIZE encoding (byte/half/word)
//   cmd_wdata_i               write data, already lane-placed
//   rsp_valid_o               one-cycle response pulse
//   rsp_error_o               bus ERROR or local misalignment
//   rsp_rdata_o               read data (0 for writes and errors)
//   rsp_wait_o                data-phase wait states, saturating at 255
//   H*_o                      AHB-Lite master outputs, all registered/constant
//   HREADY_i, HRESP_i, HRDATA_i  AHB-Lite inputs from the interconnect
// -----------------------------------------------------------------------------
module ahb_lite_master #(
   parameter int          ADDR_W    = 32,
   parameter int          DATA_W    = 32,
   parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
   input  logic              HCLK_i,
   input  logic              HRESETn_i,
   // command side
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_write_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [2:0]        cmd_size_i,
   input  logic [DATA_W-1:0] cmd_wdata_i,
   // response side
   output logic              rsp_valid_o,
   output logic              rsp_error_o,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic [7:0]        rsp_wait_o,
   // AHB-Lite master
   output logic [ADDR_W-1:0] HADDR_o,
   output logic              HWRITE_o,
   output logic [2:0]        HSIZE_o,
   output logic [2:0]        HBURST_o,
   output logic [3:0]        HPROT_o,
   output logic [1:0]        HTRANS_o,
   output logic              HMASTLOCK_o,
   output logic [DATA_W-1:0] HWDATA_o,
   input  logic              HREADY_i,
   input  logic              HRESP_i,
   input  logic [DATA_W-1:0] HRDATA_i
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_RESP
   } state_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   state_e            state_q,     state_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic [ADDR_W-1:0] haddr_q,     haddr_d;
   logic              hwrite_q,    hwrite_d;
   logic [2:0]        hsize_q,     hsize_d;
   logic [1:0]        htrans_q,    htrans_d;
   logic [DATA_W-1:0] hwdata_q,    hwdata_d;
   logic [DATA_W-1:0] wdata_q,     wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_error_q, rsp_error_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [7:0]        rsp_wait_q,  rsp_wait_d;

   logic accept;
   logic misaligned;

   assign accept = cmd_valid_i & cmd_ready_q;

   // Sizes above word are not supported by this 32-bit master and are
   // treated the same as a misaligned address.
   assign misaligned = ((cmd_size_i == 3'b001) && cmd_addr_i[0])
                     | ((cmd_size_i == 3'b010) && (cmd_addr_i[1:0] != 2'b00))
                     | (cmd_size_i > 3'b010);

   // NOTE: every _d gets its hold value first, so no path through the case
   // below leaves a signal unassigned and no latch can be inferred.
   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      haddr_d     = haddr_q;
      hwrite_d    = hwrite_q;
      hsize_d     = hsize_q;
      htrans_d    = htrans_q;
      hwdata_d    = hwdata_q;
      wdata_d     = wdata_q;
      rsp_valid_d = 1'b0;
      rsp_error_d = rsp_error_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_wait_d  = rsp_wait_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               cmd_ready_d = 1'b0;
               wdata_d     = cmd_wdata_i;
               rsp_error_d = 1'b0;
               rsp_rdata_d = '0;
               rsp_wait_d  = 8'd0;
               if (misaligned) begin
                  // Rejected locally: answer straight away, bus stays IDLE.
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_error_d = 1'b1;
               end else begin
                  state_d  = S_ADDR;
                  htrans_d = HTRANS_NONSEQ;
                  haddr_d  = cmd_addr_i;
                  hwrite_d = cmd_write_i;
                  hsize_d  = cmd_size_i;
               end
            end
         end

         S_ADDR: begin
            // Address-phase outputs simply hold while the bus stalls.
            if (HREADY_i) begin
               state_d  = S_DATA;
               htrans_d = HTRANS_IDLE;
               if (hwrite_q) begin
                  hwdata_d = wdata_q;
               end
            end
         end

         S_DATA: begin
            if (!HREADY_i) begin
               if (rsp_wait_q != 8'hFF) begin
                  rsp_wait_d = rsp_wait_q + 8'd1;
               end
            end else begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_error_d = HRESP_i;
               rsp_rdata_d = (!HRESP_i && !hwrite_q) ? HRDATA_i : '0;
            end
         end

         S_RESP: begin
            state_d     = S_IDLE;
            cmd_ready_d = 1'b1;
         end

         default: begin
            state_d     = S_IDLE;
            cmd_ready_d = 1'b1;
            htrans_d    = HTRANS_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of the others, independent of statement order.
   always_ff @(posedge HCLK_i or negedge HRESETn_i) begin
      if (!HRESETn_i) begin
         state_q     <= S_IDLE;
         cmd_ready_q <= 1'b1;
         haddr_q     <= '0;
         hwrite_q    <= 1'b0;
         hsize_q     <= 3'b000;
         htrans_q    <= HTRANS_IDLE;
         hwdata_q    <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_wait_q  <= 8'd0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         haddr_q     <= haddr_d;
         hwrite_q    <= hwrite_d;
         hsize_q     <= hsize_d;
         htrans_q    <= htrans_d;
         hwdata_q    <= hwdata_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_error_q <= rsp_error_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_wait_q  <= rsp_wait_d;
      end
   end

   assign cmd_ready_o = cmd_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_error_o = rsp_error_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_wait_o  = rsp_wait_q;

   assign HADDR_o     = haddr_q;
   assign HWRITE_o    = hwrite_q;
   assign HSIZE_o     = hsize_q;
   assign HBURST_o    = 3'b000;
   assign HPROT_o     = HPROT_VAL;
   assign HTRANS_o    = htrans_q;
   assign HMASTLOCK_o = 1'b0;
   assign HWDATA_o    = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// -----------------------------------------------------------------------------
// tb_ahb_lite_master
//
// Self-checking bench for ahb_lite_master. The bench plays the AHB slave,
// drives commands, and compares bus activity and responses against a
// transaction-level expectation computed from the command and the slave
// behaviour chosen for it (alignment rule, saturated wait count, data rules).
// -----------------------------------------------------------------------------
module tb_ahb_lite_master;

   logic        HCLK_i;
   logic        HRESETn_i;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic        cmd_write_i;
   logic [31:0] cmd_addr_i;
   logic [2:0]  cmd_size_i;
   logic [31:0] cmd_wdata_i;
   logic        rsp_valid_o;
   logic        rsp_error_o;
   logic [31:0] rsp_rdata_o;
   logic [7:0]  rsp_wait_o;
   logic [31:0] HADDR_o;
   logic        HWRITE_o;
   logic [2:0]  HSIZE_o;
   logic [2:0]  HBURST_o;
   logic [3:0]  HPROT_o;
   logic [1:0]  HTRANS_o;
   logic        HMASTLOCK_o;
   logic [31:0] HWDATA_o;
   logic        HREADY_i;
   logic        HRESP_i;
   logic [31:0] HRDATA_i;

   int n_checks = 0;
   int n_errors = 0;

   ahb_lite_master #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .HPROT_VAL(4'b0011)
   ) dut (
      .HCLK_i      (HCLK_i),
      .HRESETn_i   (HRESETn_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_write_i (cmd_write_i),
      .cmd_addr_i  (cmd_addr_i),
      .cmd_size_i  (cmd_size_i),
      .cmd_wdata_i (cmd_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_error_o (rsp_error_o),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_wait_o  (rsp_wait_o),
      .HADDR_o     (HADDR_o),
      .HWRITE_o    (HWRITE_o),
      .HSIZE_o     (HSIZE_o),
      .HBURST_o    (HBURST_o),
      .HPROT_o     (HPROT_o),
      .HTRANS_o    (HTRANS_o),
      .HMASTLOCK_o (HMASTLOCK_o),
      .HWDATA_o    (HWDATA_o),
      .HREADY_i    (HREADY_i),
      .HRESP_i     (HRESP_i),
      .HRDATA_i    (HRDATA_i)
   );

   initial HCLK_i = 1'b0;
   always #5 HCLK_i = ~HCLK_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_htrans"},    32'(HTRANS_o),    32'd0);
      check({tag, "_haddr"},     HADDR_o,          32'd0);
      check({tag, "_hwrite"},    32'(HWRITE_o),    32'd0);
      check({tag, "_hsize"},     32'(HSIZE_o),     32'd0);
      check({tag, "_hburst"},    32'(HBURST_o),    32'd0);
      check({tag, "_hprot"},     32'(HPROT_o),     32'h3);
      check({tag, "_hmastlock"}, 32'(HMASTLOCK_o), 32'd0);
      check({tag, "_hwdata"},    HWDATA_o,         32'd0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
      check({tag, "_rsp_error"}, 32'(rsp_error_o), 32'd0);
      check({tag, "_rsp_rdata"}, rsp_rdata_o,      32'd0);
      check({tag, "_rsp_wait"},  32'(rsp_wait_o),  32'd0);
      check({tag, "_cmd_ready"}, 32'(cmd_ready_o), 32'd1);
   endtask

   // Transaction-level rule: an access must sit on a multiple of its size,
   // and only byte/half/word sizes exist.
   function automatic logic is_misaligned(input logic [2:0] size, input logic [31:0] addr);
      int bytes;
      if (size > 3'd2) return 1'b1;
      bytes = 1 << size;
      return (addr % bytes) != 0;
   endfunction

   // One complete command: present it, play the slave with aw address-phase
   // stalls and dw data-phase stalls (plus one extra ERROR stall when err),
   // then compare bus activity and the response with the expected outcome.
   // Always returns at a falling edge with cmd_ready_o expected high.
   task automatic run_cmd(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wdata,
                          input int aw, input int dw, input logic err,
                          input logic [31:0] rdata, input logic hold_valid);
      logic        mis;
      int          budget;
      int          total;
      logic [31:0] exp_rdata;
      logic [31:0] exp_wait;
      mis         = is_misaligned(size, addr);
      cmd_write_i = wr;
      cmd_addr_i  = addr;
      cmd_size_i  = size;
      cmd_wdata_i = wdata;
      cmd_valid_i = 1'b1;
      budget      = 0;
      while (!cmd_ready_o && budget < 20) begin
         @(negedge HCLK_i);
         budget++;
      end
      if (!cmd_ready_o) begin
         check({tag, "_ready_timeout"}, 32'(cmd_ready_o), 32'd1);
         cmd_valid_i = 1'b0;
         return;
      end
      @(negedge HCLK_i);
      if (!hold_valid) cmd_valid_i = 1'b0;
      check({tag, "_ready_busy"}, 32'(cmd_ready_o), 32'd0);

      if (mis) begin
         check({tag, "_mis_valid"}, 32'(rsp_valid_o), 32'd1);
         check({tag, "_mis_error"}, 32'(rsp_error_o), 32'd1);
         check({tag, "_mis_rdata"}, rsp_rdata_o,      32'd0);
         check({tag, "_mis_wait"},  32'(rsp_wait_o),  32'd0);
         check({tag, "_mis_htrans"}, 32'(HTRANS_o),   32'd0);
         @(negedge HCLK_i);
         check({tag, "_mis_valid_end"}, 32'(rsp_valid_o), 32'd0);
         check({tag, "_mis_ready_end"}, 32'(cmd_ready_o), 32'd1);
         check({tag, "_mis_htrans_end"}, 32'(HTRANS_o),   32'd0);
         return;
      end

      // address phase
      for (int i = 0; i <= aw; i++) begin
         HREADY_i = (i == aw);
         check({tag, "_a_htrans"},    32'(HTRANS_o),    32'd2);
         check({tag, "_a_haddr"},     HADDR_o,          addr);
         check({tag, "_a_hwrite"},    32'(HWRITE_o),    32'(wr));
         check({tag, "_a_hsize"},     32'(HSIZE_o),     32'(size));
         check({tag, "_a_hburst"},    32'(HBURST_o),    32'd0);
         check({tag, "_a_hmastlock"}, 32'(HMASTLOCK_o), 32'd0);
         check({tag, "_a_hprot"},     32'(HPROT_o),     32'h3);
         check({tag, "_a_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
         @(negedge HCLK_i);
      end

      // data phase; an ERROR response spends its first cycle as a stall
      total = dw + (err ? 1 : 0);
      for (int i = 0; i <= total; i++) begin
         HREADY_i = (i == total);
         HRESP_i  = err && (i >= total - 1);
         HRDATA_i = (i == total) ? rdata : $urandom;
         check({tag, "_d_htrans"},    32'(HTRANS_o),    32'd0);
         check({tag, "_d_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
         if (wr) check({tag, "_d_hwdata"}, HWDATA_o, wdata);
         @(negedge HCLK_i);
      end
      HREADY_i = 1'b1;
      HRESP_i  = 1'b0;
      HRDATA_i = $urandom;

      exp_rdata = (wr || err) ? 32'd0 : rdata;
      exp_wait  = (total > 255) ? 32'd255 : 32'(total);
      check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd1);
      check({tag, "_rsp_error"}, 32'(rsp_error_o), 32'(err));
      check({tag, "_rsp_rdata"}, rsp_rdata_o,      exp_rdata);
      check({tag, "_rsp_wait"},  32'(rsp_wait_o),  exp_wait);
      check({tag, "_rsp_ready"}, 32'(cmd_ready_o), 32'd0);
      check({tag, "_rsp_htrans"}, 32'(HTRANS_o),   32'd0);
      @(negedge HCLK_i);
      check({tag, "_end_valid"}, 32'(rsp_valid_o), 32'd0);
      check({tag, "_end_ready"}, 32'(cmd_ready_o), 32'd1);
   endtask

   initial begin
      logic [2:0]  r_size;
      logic [31:0] r_addr;
      HRESETn_i   = 1'b0;
      cmd_valid_i = 1'b0;
      cmd_write_i = 1'b0;
      cmd_addr_i  = 32'd0;
      cmd_size_i  = 3'd0;
      cmd_wdata_i = 32'd0;
      HREADY_i    = 1'b1;
      HRESP_i     = 1'b0;
      HRDATA_i    = 32'd0;

      #12;
      check_reset_outputs("por");
      @(negedge HCLK_i);
      HRESETn_i = 1'b1;
      @(negedge HCLK_i);

      // directed cases
      run_cmd("wr0",   1'b1, 32'h100, 3'd2, 32'hDEADBEEF, 0, 0, 1'b0, 32'h0, 1'b0);
      run_cmd("rd3w",  1'b0, 32'h200, 3'd2, 32'h0,        0, 3, 1'b0, 32'h12345678, 1'b0);
      run_cmd("wr3w",  1'b1, 32'h204, 3'd2, 32'hCAFEF00D, 2, 3, 1'b0, 32'h0, 1'b0);
      run_cmd("rderr", 1'b0, 32'h300, 3'd2, 32'h0,        0, 0, 1'b1, 32'hAAAA5555, 1'b0);
      run_cmd("mis_w", 1'b0, 32'h102, 3'd2, 32'h0,        0, 0, 1'b0, 32'h0, 1'b0);
      run_cmd("mis_h", 1'b1, 32'h3,   3'd1, 32'h11223344, 0, 0, 1'b0, 32'h0, 1'b0);
      run_cmd("mis_s", 1'b0, 32'h0,   3'd3, 32'h0,        0, 0, 1'b0, 32'h0, 1'b0);

      // reset in the middle of a stalled data phase
      cmd_write_i = 1'b0;
      cmd_addr_i  = 32'h400;
      cmd_size_i  = 3'd2;
      cmd_valid_i = 1'b1;
      @(negedge HCLK_i);
      cmd_valid_i = 1'b0;
      check("rst_addr_phase", 32'(HTRANS_o), 32'd2);
      HREADY_i = 1'b1;
      @(negedge HCLK_i);
      check("rst_data_phase", 32'(HTRANS_o), 32'd0);
      HREADY_i = 1'b0;
      @(negedge HCLK_i);
      @(negedge HCLK_i);
      #2 HRESETn_i = 1'b0;
      #1 check_reset_outputs("midrst");
      for (int i = 0; i < 3; i++) begin
         @(negedge HCLK_i);
         check("midrst_no_rsp", 32'(rsp_valid_o), 32'd0);
      end
      HRESETn_i = 1'b1;
      HREADY_i  = 1'b1;
      @(negedge HCLK_i);
      check("post_rst_no_rsp", 32'(rsp_valid_o), 32'd0);
      run_cmd("byte7", 1'b0, 32'h7, 3'd0, 32'h0, 0, 1, 1'b0, 32'h5A000000, 1'b0);

      // back-to-back with cmd_valid held high, one long stall
      run_cmd("b2b0", 1'b1, 32'h500, 3'd2, 32'h01020304, 0, 0,   1'b0, 32'h0,        1'b1);
      run_cmd("b2b1", 1'b0, 32'h504, 3'd1, 32'h0,        0, 300, 1'b0, 32'h0BADF00D, 1'b1);
      run_cmd("b2b2", 1'b0, 32'h508, 3'd2, 32'h0,        1, 0,   1'b0, 32'h87654321, 1'b0);

      // randomized commands
      for (int n = 0; n < 40; n++) begin
         r_size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         r_addr = $urandom;
         if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~((32'd1 << r_size[1:0]) - 32'd1);
         run_cmd("rnd", 1'($urandom_range(0, 1)), r_addr, r_size, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 4),
                 ($urandom_range(0, 4) == 0), $urandom, 1'($urandom_range(0, 1)));
      end
      cmd_valid_i = 1'b0;
      @(negedge HCLK_i);
      check("final_idle", 32'(HTRANS_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ahb_lite_master.md
# ahb_lite_master

Single-transfer AHB-Lite master that converts a simple command/response interface into AHB NONSEQ transfers. It is the AHB-initiating side of the APB-to-AHB bridge: the APB-facing logic issues one command at a time, and this block drives the AHB address and data phases to the bridge's AHB slaves. It supports byte, halfword and word transfers, rejects misaligned commands locally, and reports completion status, read data and wait-state count.

## Interface
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32 for this block.
- HPROT_VAL, 4'b0011, constant driven on HPROT_o (non-cacheable, non-bufferable, privileged, data).
- HCLK_i  in  1  bus clock; all logic on the rising edge.
- HRESETn_i  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  block can accept a command.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_W  byte address.
- cmd_size_i  in  3  HSIZE encoding: 000 = byte, 001 = half, 010 = word.
- cmd_wdata_i  in  DATA_W  write data, already lane-placed by the caller.
- rsp_valid_o  out  1  one-cycle pulse; response fields valid.
- rsp_error_o  out  1  1 = ERROR (bus or local misalignment).
- rsp_rdata_o  out  DATA_W  read data; 0 for writes and errors.
- rsp_wait_o  out  8  data-phase wait states seen; saturates at 255.
- HADDR_o, HWRITE_o, HSIZE_o[2:0], HBURST_o[2:0], HPROT_o[3:0], HTRANS_o[1:0], HMASTLOCK_o, HWDATA_o[31:0]  out  AHB-Lite master outputs.
- HREADY_i  in  1  transfer-done/ready from the interconnect.
- HRESP_i  in  1  0 = OKAY, 1 = ERROR.
- HRDATA_i  in  32  read data.

## Operation
- **States:**
  - IDLE: cmd_ready_o = 1, HTRANS_o = IDLE.
  - ADDR: address phase.
  - DATA: data phase.
  - RESP: one cycle, rsp_valid_o = 1.
- **Command accept:** a command is accepted on an edge with cmd_valid_i & cmd_ready_o. Command fields are registered at that edge.
- **Alignment check on accept:**
  - Misaligned cases: size 001 with addr[0] = 1; size 010 with addr[1:0] ≠ 0; size > 010.
  - Action: go to RESP with rsp_error_o = 1, rsp_rdata_o = 0, rsp_wait_o = 0. No bus activity.
- **Aligned accept:** go to ADDR. Drive HTRANS_o = NONSEQ (10), HADDR_o, HWRITE_o and HSIZE_o from the registered command, HBURST_o = 000 (SINGLE), HMASTLOCK_o = 0.
- **ADDR:** hold all address-phase outputs while HREADY_i = 0. On an edge with HREADY_i = 1, go to DATA and set HTRANS_o = IDLE. For writes, drive HWDATA_o = registered wdata.
- **DATA:**
  - Each edge with HREADY_i = 0 increments the wait counter, saturating at 255.
  - On an edge with HREADY_i = 1: capture rsp_error_o = HRESP_i, and rsp_rdata_o = HRDATA_i for an OKAY read (0 otherwise). Then go to RESP.
  - HWDATA_o stays stable for the whole data phase.
- **ERROR response:** the first ERROR cycle has HRESP_i = 1 with HREADY_i = 0 and counts as a wait state. Completion happens on the second cycle (HRESP_i = 1, HREADY_i = 1).
- **RESP:** rsp_valid_o = 1 for exactly one cycle, then IDLE. There is no backpressure on the response.
- **Reset values (immediate on HRESETn_i low):**
  - AHB outputs: HTRANS_o = 00, HADDR_o = 0, HWRITE_o = 0, HSIZE_o = 000, HBURST_o = 000, HPROT_o = HPROT_VAL, HMASTLOCK_o = 0, HWDATA_o = 0.
  - Response and handshake: rsp_valid_o = 0, rsp_error_o = 0, rsp_rdata_o = 0, rsp_wait_o = 0, cmd_ready_o = 1, state = IDLE.
- **Reset mid-transfer:** the command in progress is dropped and no response is produced.

## Timing
- Zero-wait transfer, with acceptance at edge E0:
  - E0–E1: address phase.
  - E1–E2: data phase.
  - rsp_valid_o high from E2 to E3.
  - cmd_ready_o high again from E3.
- Each HREADY_i-low cycle in ADDR or DATA adds one cycle of latency. Only DATA-phase cycles count in rsp_wait_o.
- Misaligned command: rsp_valid_o high for the cycle E0–E1, and cmd_ready_o is low for that cycle.
- cmd_ready_o is registered and low from the accept edge until the RESP cycle has ended. A new command can therefore be accepted every 3 cycles at best.
- All outputs are registered; no combinational path from AHB inputs to AHB outputs.

## Test plan
- **Zero-wait word write:** cmd write, addr 0x100, size 010, wdata 0xDEADBEEF, HREADY_i = 1 → NONSEQ with HADDR_o = 0x100 for one cycle, HWDATA_o = 0xDEADBEEF the next cycle, then rsp_valid_o with error = 0, wait = 0.
- **Word read with 3 wait states:** addr 0x200, HREADY_i low for 3 data-phase cycles, HRDATA_i = 0x12345678 → rsp_rdata_o = 0x12345678, rsp_wait_o = 3, HWDATA_o stable throughout.
- **Two-cycle ERROR response:** read that receives the ERROR sequence → rsp_error_o = 1, rsp_rdata_o = 0, rsp_wait_o = 1.
- **Misaligned commands:** size 010 at addr 0x102, and size 001 at addr 0x3 → rsp_valid_o on the next cycle with error = 1, HTRANS_o stays IDLE throughout.
- **Reset mid-transfer:** HRESETn_i asserted in DATA with HREADY_i = 0 → all outputs at reset values immediately, no rsp_valid_o. After release, a byte read at 0x7 completes normally with HSIZE_o = 000.
- **Back-to-back commands:** cmd_valid_i held high with 3 commands, 300 wait states injected on one of them → one response per command, in order, and rsp_wait_o saturates at 255 for that command.
